div: RTL and testbench

Iterative 32-bit signed divider for the processor's multiply/divide unit; it is the inverse counterpart to the Booth multiplier and shares the same HI/LO result convention. A one-cycle start pulse latches dividend and divisor. The block runs a 32-step restoring division on operand magnitudes, applies sign correction, and writes quotient to `resultLo` and remainder to `resultHi`. The control unit waits on `divDone` before reading HI/LO.

---
 rtl/div_if.sv | 34 +++
 rtl/div.sv | 120 ++++++++++++
 tb/tb_div.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: operand/result bundle between the control unit and the divider.
// master = control unit, slave = divider.
interface div_if;
  logic        DivControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] resultHi;
  logic [31:0] resultLo;
  logic        divBusy;
  logic        divDone;
  logic        divZero;

  modport master (
    output DivControl,
    output A,
    output B,
    input  resultHi,
    input  resultLo,
    input  divBusy,
    input  divDone,
    input  divZero
  );

  modport slave (
    input  DivControl,
    input  A,
    input  B,
    output resultHi,
    output resultLo,
    output divBusy,
    output divDone,
    output divZero
  );
endinterface

// File: rtl/div.sv
// div: 32-step restoring signed divider, quotient->LO, remainder->HI.
// Optional macro DIV_ZERO_TRAP_EN: trap B==0 at start instead of running.
module div (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;
  logic        zdiv;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        zero;

  logic        trap;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

`ifdef DIV_ZERO_TRAP_EN
  assign trap = (bus.B == 32'd0);
`else
  assign trap = 1'b0;
`endif

  assign a_mag = bus.A[31] ? -bus.A : bus.A;
  assign b_mag = bus.B[31] ? -bus.B : bus.B;
  assign trial = {rem, quo[31]} - {1'b0, dvsr};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  assign bus.resultHi = hi;
  assign bus.resultLo = lo;
  assign bus.divBusy  = busy;
  assign bus.divDone  = done;
  assign bus.divZero  = zero;

  // Control FSM plus datapath; a start in any state restarts the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      zdiv  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.DivControl) begin
        if (trap) begin
          zero  <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          cnt   <= '0;
        end else begin
          zero  <= 1'b0;
          rem   <= '0;
          quo   <= a_mag;
          dvsr  <= b_mag;
          neg_r <= bus.A[31];
          neg_q <= bus.A[31] ^ bus.B[31];
          zdiv  <= (bus.B == 32'd0);
          cnt   <= 6'd32;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= {rem[30:0], quo[31]};
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) state <= FIX;
          end
          FIX: begin
            lo    <= zdiv ? quo : q_fix;
            hi    <= zdiv ? rem : r_fix;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: directed-vector bench for the iterative signed divider.
// Build with or without +define+DIV_ZERO_TRAP_EN.
module tb_div;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  div_if bus ();

  div u_div (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [31:0] b);
    bus.DivControl = 1'b1;
    bus.A = a;
    bus.B = b;
    tick();
    bus.DivControl = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
  endtask

  task automatic wait_done(input string tag,
                           input logic [31:0] q,
                           input logic [31:0] r);
    int n;
    int nb;
    n  = 0;
    nb = bus.divBusy ? 1 : 0;
    while (!bus.divDone && n < 100) begin
      tick();
      n++;
      if (bus.divBusy) nb++;
    end
    chk({tag, " lat"}, n, 33);
    chk({tag, " busycyc"}, nb, 33);
    chk({tag, " lo"}, bus.resultLo, q);
    chk({tag, " hi"}, bus.resultHi, r);
    chk({tag, " zero"}, bus.divZero, 0);
    tick();
    chk({tag, " donepulse"}, bus.divDone, 0);
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] q,
                        input logic [31:0] r);
    start(a, b);
    chk({tag, " busy"}, bus.divBusy, 1);
    chk({tag, " done0"}, bus.divDone, 0);
    wait_done(tag, q, r);
  endtask

  initial begin
    int nd;
    n_chk  = 0;
    n_fail = 0;
    bus.DivControl = 1'b0;
    bus.A = '0;
    bus.B = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst hi", bus.resultHi, 0);
    chk("rst lo", bus.resultLo, 0);
    chk("rst busy", bus.divBusy, 0);
    chk("rst done", bus.divDone, 0);
    chk("rst zero", bus.divZero, 0);

    run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("-100/7", -32'sd100, 32'd7,
           32'hFFFFFFF2, 32'hFFFFFFFE);
    run_op("100/-7", 32'd100, -32'sd7,
           32'hFFFFFFF2, 32'd2);
    run_op("min/-1", 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 32'd0);
    run_op("-7/-2", -32'sd7, -32'sd2,
           32'd3, 32'hFFFFFFFF);
    run_op("5/9", 32'd5, 32'd9, 32'd0, 32'd5);

`ifdef DIV_ZERO_TRAP_EN
    start(32'd42, 32'd0);
    chk("z zero", bus.divZero, 1);
    chk("z done", bus.divDone, 1);
    chk("z busy", bus.divBusy, 0);
    chk("z lo", bus.resultLo, 32'd0);
    chk("z hi", bus.resultHi, 32'd5);
    tick();
    chk("z done1", bus.divDone, 0);
    chk("z hold", bus.divZero, 1);
    run_op("after z", 32'd9, 32'd2, 32'd4, 32'd1);
`else
    run_op("42/0", 32'd42, 32'd0,
           32'hFFFFFFFF, 32'd42);
`endif

    start(32'd100, 32'd7);
    repeat (9) tick();
    chk("abort nodone", bus.divDone, 0);
    start(32'd81, 32'd9);
    wait_done("abort 81/9", 32'd9, 32'd0);

    start(32'd100, 32'd7);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst hi", bus.resultHi, 0);
    chk("mrst lo", bus.resultLo, 0);
    chk("mrst busy", bus.divBusy, 0);
    chk("mrst done", bus.divDone, 0);
    chk("mrst zero", bus.divZero, 0);
    nd = 0;
    repeat (40) begin
      tick();
      if (bus.divDone) nd++;
    end
    chk("mrst nodone", nd, 0);
    run_op("post rst", 32'd100, 32'd7, 32'd14, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
